// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode constants, a constant clog2
// and the wrap-around pointer increment used by every FIFO variant.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result = result + 1;
      return result;
   endfunction

   // Pointers walk 0..depth-1, so non-power-of-two depths wrap explicitly.
   function automatic int fifo_ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 5,
   parameter int PTR_W      = 3
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [PTR_W-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through reads,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 5,
   parameter int FWFT       = FIFO_MODE_STD,
   parameter int AF_LEVEL   = 4,
   parameter int AE_LEVEL   = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr_en,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   output logic                             wr_ready,
   input  logic                             rd_en,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_val,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             almost_full,
   output logic                             almost_empty,
   output logic                             overflow,
   output logic                             underflow,
   input  logic                             clr_err
);

   localparam int PTR_W = fifo_clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_val_q, rd_val_d;

   logic                  full, not_empty, wr_acc, rd_acc, mem_we;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   always_comb begin
      full        = (count_q == DEPTH_C);
      not_empty   = (count_q != '0);
      wr_acc      = wr_en & ~full;
      rd_acc      = rd_en & not_empty;
      // The array has no reset, so keep it untouched while reset is held.
      mem_we      = wr_acc & reset;

      wr_ptr_d    = wr_acc ? PTR_W'(fifo_ptr_inc(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
      rd_ptr_d    = rd_acc ? PTR_W'(fifo_ptr_inc(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;

      count_d     = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A new error in the same cycle wins over the clear request.
      overflow_d  = clr_err ? 1'b0 : overflow_q;
      underflow_d = clr_err ? 1'b0 : underflow_q;
      if (wr_en & full)       overflow_d  = 1'b1;
      if (rd_en & ~not_empty) underflow_d = 1'b1;

      rd_val_d    = rd_acc;
      rd_data_d   = rd_acc ? mem_rd_data : rd_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_data_q   <= '0;
         rd_val_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_data_q   <= rd_data_d;
         rd_val_q    <= rd_val_d;
      end
   end

   assign wr_ready     = ~full;
   assign count        = count_q;
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // FWFT presents the head entry straight from the array; zero when empty.
   assign rd_val  = (FWFT == FIFO_MODE_FWFT) ? not_empty : rd_val_q;
   assign rd_data = (FWFT == FIFO_MODE_FWFT) ? (not_empty ? mem_rd_data : '0) : rd_data_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a standard-read and an FWFT instance share stimulus and
// are compared against a queue-based reference model of the FIFO contract.
module tb_fifo_param;

  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       reset, wr_en, rd_en, clr_err;
  logic [7:0] wr_data;

  logic       s_wr_ready, s_rd_val, s_af, s_ae, s_ovf, s_udf;
  logic [7:0] s_rd_data;
  logic [2:0] s_count;
  logic       f_wr_ready, f_rd_val, f_af, f_ae, f_ovf, f_udf;
  logic [7:0] f_rd_data;
  logic [2:0] f_count;

  logic [7:0] q[$];
  logic [7:0] m_std_data;
  logic       m_std_val, m_ovf, m_udf;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(s_wr_ready),
    .rd_en(rd_en), .rd_data(s_rd_data), .rd_val(s_rd_val), .count(s_count),
    .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf),
    .clr_err(clr_err));

  fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(f_wr_ready),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_val(f_rd_val), .count(f_count),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf),
    .clr_err(clr_err));

  task automatic model_clear();
    q.delete();
    m_std_data = 8'h00;
    m_std_val  = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // One clock of stimulus; the model advances from the contract rules.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit full, empty;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    m_std_val = 1'b0;
    if (r && !empty) begin
      m_std_data = q.pop_front();
      m_std_val  = 1'b1;
    end
    if (w && !full) q.push_back(d);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (w && full)  m_ovf = 1'b1;
    if (r && empty) m_udf = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    #1 reset = 1'b0;
    #2;
    model_clear();
    checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", s_count); end
    checks++; if (s_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", s_wr_ready); end
    checks++; if (s_ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", s_ae); end
    checks++; if (s_af !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", s_af); end
    checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", s_ovf, s_udf);
    end
    checks++; if (s_rd_val !== 1'b0 || s_rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_std_rd: got val=%b data=%0h expected 0 0", s_rd_val, s_rd_data);
    end
    checks++; if (f_rd_val !== 1'b0) begin errors++; $display("FAIL reset_fwft_val: got %b expected 0", f_rd_val); end
    wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk); #1;
    checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL reset_write_ignored: got %0d expected 0", s_count); end
    wr_en = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      checks++; if (s_count !== 3'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", s_count, i); end
      checks++; if (s_wr_ready !== (i < 5)) begin errors++; $display("FAIL fill_wr_ready: got %b expected %b", s_wr_ready, (i < 5)); end
      checks++; if (s_af !== (i >= AF)) begin errors++; $display("FAIL fill_almost_full: got %b expected %b", s_af, (i >= AF)); end
      checks++; if (s_ae !== (i <= AE)) begin errors++; $display("FAIL fill_almost_empty: got %b expected %b", s_ae, (i <= AE)); end
    end
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    checks++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin
      errors++; $display("FAIL fill_overflow: got %b/%b expected 1/1", s_ovf, f_ovf);
    end
    checks++; if (s_count !== 3'd5) begin errors++; $display("FAIL fill_count_after_ovf: got %0d expected 5", s_count); end
    checks++; if (f_rd_data !== 8'h01) begin errors++; $display("FAIL fill_head_unchanged: got %0h expected 1", f_rd_data); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (s_rd_val !== 1'b1) begin errors++; $display("FAIL drain_rd_val: got %b expected 1", s_rd_val); end
      checks++; if (s_rd_data !== 8'(i + 1)) begin errors++; $display("FAIL drain_rd_data: got %0h expected %0h", s_rd_data, i + 1); end
      checks++; if (s_count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count: got %0d expected %0d", s_count, 4 - i); end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (s_rd_val !== 1'b0 || s_rd_data !== 8'h05) begin
      errors++; $display("FAIL drain_hold: got val=%b data=%0h expected 0 5", s_rd_val, s_rd_data);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (s_udf !== 1'b1 || s_rd_val !== 1'b0 || s_count !== 3'd0) begin
      errors++; $display("FAIL drain_underflow: got udf=%b val=%b count=%0d expected 1 0 0", s_udf, s_rd_val, s_count);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin
      errors++; $display("FAIL drain_clr_err: got ovf=%b udf=%b expected 0 0", s_ovf, s_udf);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_next;
    exp_next = 8'hA0;
    cycle(1'b1, 8'hA0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    for (int k = 2; k < 14; k++) begin
      cycle(k < 12, 8'(8'hA0 + k), 1'b1, 1'b0);
      checks++; if (s_rd_val !== 1'b1 || s_rd_data !== exp_next) begin
        errors++; $display("FAIL wrap_data: got val=%b data=%0h expected 1 %0h", s_rd_val, s_rd_data, exp_next);
      end
      checks++; if (s_count !== 3'(q.size()) || s_count > 3'd5) begin
        errors++; $display("FAIL wrap_count: got %0d expected %0d", s_count, q.size());
      end
      exp_next = exp_next + 8'h01;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'(8'h20 + k), 1'b1, 1'b0);
      checks++; if (s_rd_val !== 1'b1 || s_rd_data !== 8'(8'h10 + k)) begin
        errors++; $display("FAIL simul_read: got val=%b data=%0h expected 1 %0h", s_rd_val, s_rd_data, 8'h10 + k);
      end
      checks++; if (s_count !== 3'd4) begin errors++; $display("FAIL simul_count: got %0d expected 4", s_count); end
    end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL simul_overflow: got %b expected 1", s_ovf); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h30, 1'b1, 1'b0);
    checks++; if (s_count !== 3'd2 || s_rd_data !== 8'h21) begin
      errors++; $display("FAIL simul_count2: got count=%0d data=%0h expected 2 21", s_count, s_rd_data);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (s_rd_data !== m_std_data) begin
        errors++; $display("FAIL simul_drain: got %0h expected %0h", s_rd_data, m_std_data);
      end
    end
    checks++; if (s_rd_data !== 8'h30) begin errors++; $display("FAIL simul_last: got %0h expected 30", s_rd_data); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_fwft();
    checks++; if (f_rd_val !== 1'b0) begin errors++; $display("FAIL fwft_empty_val: got %b expected 0", f_rd_val); end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (f_rd_val !== 1'b1 || f_rd_data !== 8'h3C) begin
      errors++; $display("FAIL fwft_visible: got val=%b data=%0h expected 1 3c", f_rd_val, f_rd_data);
    end
    checks++; if (s_rd_val !== 1'b0) begin errors++; $display("FAIL fwft_std_idle: got %b expected 0", s_rd_val); end
    cycle(1'b1, 8'h4D, 1'b0, 1'b0);
    checks++; if (f_rd_data !== 8'h3C) begin errors++; $display("FAIL fwft_head_kept: got %0h expected 3c", f_rd_data); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (f_rd_val !== 1'b1 || f_rd_data !== 8'h4D) begin
      errors++; $display("FAIL fwft_next_head: got val=%b data=%0h expected 1 4d", f_rd_val, f_rd_data);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (f_rd_val !== 1'b0) begin errors++; $display("FAIL fwft_pop: got %b expected 0", f_rd_val); end
    checks++; if (s_rd_val !== 1'b1 || s_rd_data !== 8'h4D) begin
      errors++; $display("FAIL fwft_std_pop: got val=%b data=%0h expected 1 4d", s_rd_val, s_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    checks++; if (s_count !== 3'd3 || s_udf !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got count=%0d udf=%b expected 3 1", s_count, s_udf);
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++; if (s_count !== 3'd0 || f_count !== 3'd0) begin
      errors++; $display("FAIL mid_count: got %0d/%0d expected 0/0", s_count, f_count);
    end
    checks++; if (s_udf !== 1'b0 || s_wr_ready !== 1'b1 || s_ae !== 1'b1) begin
      errors++; $display("FAIL mid_flags: got udf=%b wr_ready=%b ae=%b expected 0 1 1", s_udf, s_wr_ready, s_ae);
    end
    checks++; if (f_rd_val !== 1'b0 || s_rd_data !== 8'h00) begin
      errors++; $display("FAIL mid_outputs: got fval=%b sdata=%0h expected 0 0", f_rd_val, s_rd_data);
    end
    @(negedge clk) reset = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    checks++; if (f_rd_data !== 8'h77 || s_count !== 3'd1) begin
      errors++; $display("FAIL mid_new_write: got data=%0h count=%0d expected 77 1", f_rd_data, s_count);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (s_rd_data !== 8'h77 || s_count !== 3'd0) begin
      errors++; $display("FAIL mid_new_read: got data=%0h count=%0d expected 77 0", s_rd_data, s_count);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (s_udf !== 1'b1) begin errors++; $display("FAIL mid_set_beats_clr: got %b expected 1", s_udf); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (s_udf !== 1'b0) begin errors++; $display("FAIL mid_clr_err: got %b expected 0", s_udf); end
  endtask

  task automatic test_random();
    int wp;
    bit w, r, c;
    for (int i = 0; i < 400; i++) begin
      wp = (((i / 40) % 2) == 0) ? 7 : 3;
      w  = ($urandom_range(0, 9) < wp);
      r  = ($urandom_range(0, 9) >= wp);
      c  = ($urandom_range(0, 15) == 0);
      cycle(w, 8'($urandom), r, c);
      checks++; if (s_count !== 3'(q.size()) || f_count !== 3'(q.size())) begin
        errors++; $display("FAIL rand_count: got %0d/%0d expected %0d", s_count, f_count, q.size());
      end
      checks++; if (s_wr_ready !== (q.size() != DEPTH) || s_af !== (q.size() >= AF) || s_ae !== (q.size() <= AE)) begin
        errors++;
        $display("FAIL rand_status: got rdy=%b af=%b ae=%b expected %b %b %b", s_wr_ready, s_af, s_ae,
                 (q.size() != DEPTH), (q.size() >= AF), (q.size() <= AE));
      end
      checks++; if (s_ovf !== m_ovf || s_udf !== m_udf || f_ovf !== m_ovf || f_udf !== m_udf) begin
        errors++; $display("FAIL rand_errflags: got %b%b/%b%b expected %b%b", s_ovf, s_udf, f_ovf, f_udf, m_ovf, m_udf);
      end
      checks++; if (s_rd_val !== m_std_val || s_rd_data !== m_std_data) begin
        errors++; $display("FAIL rand_std_read: got val=%b data=%0h expected %b %0h", s_rd_val, s_rd_data, m_std_val, m_std_data);
      end
      checks++; if (f_rd_val !== (q.size() != 0) || (q.size() != 0 && f_rd_data !== q[0])) begin
        errors++;
        $display("FAIL rand_fwft_read: got val=%b data=%0h expected %b %0h", f_rd_val, f_rd_data,
                 (q.size() != 0), (q.size() != 0) ? q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
